// File: rtl/bus_arbiter_rr.sv
// ============================================================================
// Module  : bus_arbiter_rr
// Purpose : Round-robin bus arbiter for four active-low REQ/GRNT masters,
//           with a hold watchdog that revokes a stuck grant.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_arbiter_rr #(
  parameter int          MASTER_NUM = 4,
  parameter logic [15:0] HOLD_LIMIT = 16'd1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [MASTER_NUM-1:0] m_req_,
  output logic [MASTER_NUM-1:0] m_grnt_,
  output logic [1:0]            owner,
  output logic                  owner_vld,
  output logic [15:0]           hold_cnt,
  output logic                  timeout_err
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [15:0] c_hold_last = HOLD_LIMIT - 16'd1;
  localparam logic [15:0] c_hold_sat  = 16'hFFFF;

  state_t                r_state;
  logic [MASTER_NUM-1:0] r_grnt_;
  logic [1:0]            r_owner;
  logic [1:0]            r_last_owner;
  logic                  r_owner_vld;
  logic [15:0]           r_hold_cnt;
  logic                  r_timeout_err;

  logic [MASTER_NUM-1:0] w_req;
  logic [MASTER_NUM-1:0] w_cand;
  logic [1:0]            w_base;
  logic [1:0]            w_idx;
  logic [1:0]            w_pick;
  logic                  w_found;
  logic                  w_owner_req;
  logic                  w_timeout;
  logic                  w_release;

  assign w_req = ~m_req_;

  // While someone owns the bus the scan starts after the owner and the owner
  // itself is masked out, so a release or a timeout never re-grants it here.
  always_comb begin
    w_base  = (r_state == ST_GRANT) ? r_owner : r_last_owner;
    w_cand  = w_req;
    if (r_state == ST_GRANT) begin
      w_cand[r_owner] = 1'b0;
    end
    w_found = 1'b0;
    w_pick  = 2'd0;
    w_idx   = 2'd0;
    for (int i = 1; i <= MASTER_NUM; i++) begin
      w_idx = w_base + 2'(i);
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_owner_req = w_req[r_owner];
    w_timeout   = (r_state == ST_GRANT) && w_owner_req &&
                  (HOLD_LIMIT != 16'd0) && (r_hold_cnt == c_hold_last);
    w_release   = (r_state == ST_GRANT) && (!w_owner_req || w_timeout);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_grnt_       <= '1;
      r_owner       <= 2'd0;
      r_last_owner  <= 2'd3;
      r_owner_vld   <= 1'b0;
      r_hold_cnt    <= 16'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      if (w_release) begin
        r_last_owner <= r_owner;
      end
      if (r_state == ST_GRANT && !w_release) begin
        if (r_hold_cnt != c_hold_sat) begin
          r_hold_cnt <= r_hold_cnt + 16'd1;
        end
      end else if (w_found) begin
        // Fresh grant from IDLE, or a gapless handover on release/timeout.
        r_state     <= ST_GRANT;
        r_owner     <= w_pick;
        r_owner_vld <= 1'b1;
        r_grnt_     <= ~(MASTER_NUM'(1) << w_pick);
        r_hold_cnt  <= 16'd0;
      end else begin
        r_state     <= ST_IDLE;
        r_owner_vld <= 1'b0;
        r_grnt_     <= '1;
        r_hold_cnt  <= 16'd0;
      end
    end
  end

  assign m_grnt_     = r_grnt_;
  assign owner       = r_owner;
  assign owner_vld   = r_owner_vld;
  assign hold_cnt    = r_hold_cnt;
  assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire
